// File: rtl/snn_pkg.sv
// Shared types and constants for the SNN inference controller.
// Holds the FSM state type and the rate-coding threshold step.
package snn_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SCAN,
    TICK,
    WAIT_DONE,
    RESULT
  } state_t;

  // Threshold increment per timestep for rate coding.
  function automatic int spike_step(int pixel_max, int timesteps);
    return (pixel_max + 1) / timesteps;
  endfunction

endpackage

// File: rtl/snn_inference_controller_rate_encoder.sv
// Rate encoder: combinational spike decision for one pixel.
// A pixel fires while its intensity exceeds t * STEP.
module rate_encoder #(
  parameter int PIXEL_BITS = 8,
  parameter int T_BITS     = 4,
  parameter int STEP       = 16
) (
  input  logic [PIXEL_BITS-1:0] pixel,
  input  logic [T_BITS-1:0]     t,
  output logic                  spike
);

  localparam int W = PIXEL_BITS + 1;
  localparam logic [W-1:0] STEP_W = W'(STEP);

  logic [W-1:0] thr;

  assign thr   = W'(t) * STEP_W;
  assign spike = {1'b0, pixel} > thr;

endmodule

// File: rtl/snn_inference_controller.sv
// SNN inference controller: rate-codes an image into spikes and ticks,
// then waits for the core result under a watchdog.
module snn_inference_controller
  import snn_pkg::*;
#(
  parameter int IMAGE_SIZE      = 256,
  parameter int IMAGE_SIZE_BITS = $clog2(IMAGE_SIZE),
  parameter int PIXEL_MAX_VALUE = 255,
  parameter int PIXEL_BITS      = $clog2(PIXEL_MAX_VALUE),
  parameter int M               = 8,
  parameter int TIMESTEPS       = 16,
  parameter int TIMEOUT_CYCLES  = 65536
) (
  input  logic                       ACLK,
  input  logic                       ARESETN,
  input  logic [PIXEL_BITS-1:0]      IMAGE [0:IMAGE_SIZE-1],
  input  logic                       NEW_IMAGE,
  output logic                       SPK_VALID,
  output logic [IMAGE_SIZE_BITS-1:0] SPK_ADDR,
  input  logic                       SPK_READY,
  output logic                       TICK_VALID,
  input  logic                       TICK_READY,
  input  logic                       CORE_DONE,
  input  logic [M-1:0]               CORE_DIGIT,
  output logic [M-1:0]               INFERED_DIGIT,
  output logic                       COPROCESSOR_RDY,
  input  logic                       RESULT_ACK,
  output logic                       BUSY,
  output logic                       OVERRUN,
  output logic                       ERROR
);

  localparam int TB = (TIMESTEPS > 1) ? $clog2(TIMESTEPS) : 1;
  localparam int WB = $clog2(TIMEOUT_CYCLES + 1);
  localparam int STEP = spike_step(PIXEL_MAX_VALUE, TIMESTEPS);

  localparam logic [IMAGE_SIZE_BITS-1:0] LAST_PIX =
    IMAGE_SIZE_BITS'(IMAGE_SIZE - 1);
  localparam logic [TB-1:0] LAST_T = TB'(TIMESTEPS - 1);
  localparam logic [WB-1:0] WD_LIMIT = WB'(TIMEOUT_CYCLES - 1);

  state_t state;
  state_t state_nxt;

  logic [IMAGE_SIZE_BITS-1:0] pix;
  logic [TB-1:0]              t;
  logic [WB-1:0]              wd;

  logic spike;
  logic start;
  logic retire;
  logic tick_hs;
  logic timeout;
  logic last_pix;

  rate_encoder #(
    .PIXEL_BITS (PIXEL_BITS),
    .T_BITS     (TB),
    .STEP       (STEP)
  ) u_enc (
    .pixel (IMAGE[pix]),
    .t     (t),
    .spike (spike)
  );

  assign BUSY = (state == SCAN) ||
                (state == TICK) ||
                (state == WAIT_DONE);

  assign last_pix = (pix == LAST_PIX);

  always_comb begin
    start   = NEW_IMAGE &&
              ((state == IDLE) || (state == RESULT));
    // A pixel retires on its handshake, or at once if it stays silent.
    retire  = (state == SCAN) &&
              (SPK_VALID ? SPK_READY : !spike);
    tick_hs = (state == TICK) && TICK_VALID && TICK_READY;
    timeout = (state == WAIT_DONE) && !CORE_DONE &&
              (wd == WD_LIMIT);
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (start) state_nxt = SCAN;
      end
      SCAN: begin
        if (retire && last_pix) state_nxt = TICK;
      end
      TICK: begin
        if (tick_hs) begin
          state_nxt = (t == LAST_T) ? WAIT_DONE : SCAN;
        end
      end
      WAIT_DONE: begin
        if (CORE_DONE || timeout) state_nxt = RESULT;
      end
      RESULT: begin
        if (start) state_nxt = SCAN;
        else if (RESULT_ACK) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state           <= IDLE;
      pix             <= '0;
      t               <= '0;
      wd              <= '0;
      SPK_VALID       <= 1'b0;
      SPK_ADDR        <= '0;
      TICK_VALID      <= 1'b0;
      INFERED_DIGIT   <= '0;
      COPROCESSOR_RDY <= 1'b0;
      OVERRUN         <= 1'b0;
      ERROR           <= 1'b0;
    end else begin
      state <= state_nxt;
      if (start) begin
        pix             <= '0;
        t               <= '0;
        OVERRUN         <= 1'b0;
        ERROR           <= 1'b0;
        COPROCESSOR_RDY <= 1'b0;
      end else if (NEW_IMAGE && BUSY) begin
        OVERRUN <= 1'b1;
      end
      unique case (state)
        SCAN: begin
          if (!SPK_VALID && spike) begin
            SPK_VALID <= 1'b1;
            SPK_ADDR  <= pix;
          end
          if (retire) begin
            SPK_VALID <= 1'b0;
            if (last_pix) begin
              pix        <= '0;
              TICK_VALID <= 1'b1;
            end else begin
              pix <= pix + 1'b1;
            end
          end
        end
        TICK: begin
          if (tick_hs) begin
            TICK_VALID <= 1'b0;
            if (t == LAST_T) wd <= '0;
            else t <= t + 1'b1;
          end
        end
        WAIT_DONE: begin
          if (CORE_DONE) begin
            INFERED_DIGIT   <= CORE_DIGIT;
            COPROCESSOR_RDY <= 1'b1;
          end else if (timeout) begin
            ERROR           <= 1'b1;
            INFERED_DIGIT   <= '1;
            COPROCESSOR_RDY <= 1'b1;
          end else begin
            wd <= wd + 1'b1;
          end
        end
        RESULT: begin
          if (!start && RESULT_ACK) COPROCESSOR_RDY <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_snn_inference_controller.sv
// Directed/randomised bench for snn_inference_controller with a
// spike-stream reference model built from the rate-coding rule.
module tb_snn_inference_controller;

  localparam int N    = 256;
  localparam int TS   = 16;
  localparam int STEP = 256 / TS;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] image [0:N-1];
  logic       new_image = 1'b0;
  logic       spk_valid;
  logic [7:0] spk_addr;
  logic       spk_ready = 1'b0;
  logic       tick_valid;
  logic       tick_ready = 1'b0;
  logic       core_done = 1'b0;
  logic [7:0] core_digit = 8'd0;
  logic [7:0] digit;
  logic       rdy;
  logic       result_ack = 1'b0;
  logic       busy;
  logic       overrun;
  logic       error;

  int passed = 0;
  int failed = 0;
  int total  = 0;
  int mode   = 0;
  int obs_q[$];
  int exp_q[$];
  int tick_cnt = 0;
  int cyc = 0;
  int last_tick_cyc = 0;
  int rdy_rise_cyc = 0;
  int stall_err = 0;
  logic       prev_valid = 1'b0;
  logic       prev_hs = 1'b0;
  logic       prev_rdy = 1'b0;
  logic [7:0] prev_addr = 8'd0;

  always #5 clk = ~clk;

  snn_inference_controller #(
    .TIMEOUT_CYCLES (100)
  ) dut (
    .ACLK            (clk),
    .ARESETN         (rst_n),
    .IMAGE           (image),
    .NEW_IMAGE       (new_image),
    .SPK_VALID       (spk_valid),
    .SPK_ADDR        (spk_addr),
    .SPK_READY       (spk_ready),
    .TICK_VALID      (tick_valid),
    .TICK_READY      (tick_ready),
    .CORE_DONE       (core_done),
    .CORE_DIGIT      (core_digit),
    .INFERED_DIGIT   (digit),
    .COPROCESSOR_RDY (rdy),
    .RESULT_ACK      (result_ack),
    .BUSY            (busy),
    .OVERRUN         (overrun),
    .ERROR           (error)
  );

  // Ready driver and handshake monitor; a handshake completes on the
  // rising edge following the falling edge where both sides are high.
  always @(negedge clk) begin
    cyc++;
    if (rst_n) begin
      if (prev_valid && !prev_hs &&
          !(spk_valid && spk_addr == prev_addr)) stall_err++;
      if (spk_valid && tick_valid) stall_err++;
    end
    case (mode)
      0: begin spk_ready = 1'b1; tick_ready = 1'b1; end
      1: begin spk_ready = ~spk_ready; tick_ready = ~tick_ready; end
      2: {spk_ready, tick_ready} = 2'($urandom);
      default: begin spk_ready = 1'b0; tick_ready = 1'b1; end
    endcase
    prev_hs    = spk_valid && spk_ready;
    prev_valid = spk_valid && rst_n;
    prev_addr  = spk_addr;
    if (rst_n && spk_valid && spk_ready) obs_q.push_back(int'(spk_addr));
    if (rst_n && tick_valid && tick_ready) begin
      obs_q.push_back(-1);
      tick_cnt++;
      last_tick_cyc = cyc;
    end
    if (rdy && !prev_rdy) rdy_rise_cyc = cyc;
    prev_rdy = rdy;
  end

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic build_exp();
    exp_q.delete();
    for (int ts = 0; ts < TS; ts++) begin
      for (int i = 0; i < N; i++) begin
        if (int'(image[i]) > ts * STEP) exp_q.push_back(i);
      end
      exp_q.push_back(-1);
    end
  endtask

  task automatic start_run();
    obs_q.delete();
    tick_cnt = 0;
    build_exp();
    new_image = 1'b1;
    step();
    new_image = 1'b0;
  endtask

  task automatic wait_ticks(int budget);
    int n = 0;
    while (tick_cnt < TS && n < budget) begin
      step();
      n++;
    end
    check("tick_count", tick_cnt, TS);
  endtask

  task automatic check_stream(string tag);
    int bad = 0;
    check({tag, "_len"}, obs_q.size(), exp_q.size());
    if (obs_q.size() == exp_q.size()) begin
      foreach (exp_q[k]) if (obs_q[k] != exp_q[k]) bad++;
    end else begin
      bad = 1;
    end
    check({tag, "_order"}, bad, 0);
    check({tag, "_stall"}, stall_err, 0);
  endtask

  task automatic finish_core(logic [7:0] d);
    step();
    core_digit = d;
    core_done = 1'b1;
    step();
    core_done = 1'b0;
    core_digit = 8'd0;
    check("done_rdy", rdy, 1);
    check("done_digit", digit, d);
    check("done_busy", busy, 0);
  endtask

  task automatic clear_image();
    for (int i = 0; i < N; i++) image[i] = 8'd0;
  endtask

  task automatic rand_image();
    for (int i = 0; i < N; i++) begin
      image[i] = ($urandom_range(3) == 0) ? 8'($urandom) : 8'd0;
    end
  endtask

  initial begin
    int n;
    logic [7:0] d;
    clear_image();
    #12;
    check("rst_spk_valid", spk_valid, 0);
    check("rst_spk_addr", spk_addr, 0);
    check("rst_tick_valid", tick_valid, 0);
    check("rst_digit", digit, 0);
    check("rst_rdy", rdy, 0);
    check("rst_busy", busy, 0);
    check("rst_overrun", overrun, 0);
    check("rst_error", error, 0);
    @(negedge clk);
    rst_n = 1'b1;
    step();

    // Single bright pixel, stray CORE_DONE while scanning.
    mode = 0;
    image[56] = 8'd81;
    start_run();
    check("start_busy", busy, 1);
    step();
    core_digit = 8'd9;
    core_done = 1'b1;
    step();
    core_done = 1'b0;
    core_digit = 8'd0;
    wait_ticks(20000);
    check_stream("single");
    n = 0;
    foreach (obs_q[k]) if (obs_q[k] == 56) n++;
    check("single_spikes", n, 6);
    finish_core(8'd5);
    repeat (3) step();
    check("rdy_held", rdy, 1);
    result_ack = 1'b1;
    step();
    result_ack = 1'b0;
    check("ack_rdy", rdy, 0);
    check("ack_busy", busy, 0);

    // Saturated image with toggling ready.
    mode = 1;
    for (int i = 0; i < N; i++) image[i] = 8'd255;
    start_run();
    wait_ticks(40000);
    check_stream("full");
    check("full_spikes", obs_q.size() - TS, 4096);
    finish_core(8'd2);
    result_ack = 1'b1;
    step();
    result_ack = 1'b0;

    // Random image with an overrun attempt mid-scan.
    mode = 2;
    rand_image();
    start_run();
    repeat (20) step();
    check("ovr_busy", busy, 1);
    new_image = 1'b1;
    step();
    new_image = 1'b0;
    step();
    check("ovr_set", overrun, 1);
    wait_ticks(40000);
    check_stream("rand_ovr");
    d = 8'($urandom_range(1, 254));
    finish_core(d);
    check("ovr_sticky", overrun, 1);

    // Random image, no CORE_DONE: watchdog fires.
    rand_image();
    start_run();
    check("restart_ovr_clr", overrun, 0);
    check("restart_rdy", rdy, 0);
    wait_ticks(40000);
    check_stream("rand_wd");
    n = 0;
    while (!rdy && n < 300) begin
      step();
      n++;
    end
    check("wd_rdy", rdy, 1);
    check("wd_error", error, 1);
    check("wd_digit", digit, 8'hFF);
    check("wd_busy", busy, 0);
    check("wd_latency", rdy_rise_cyc - last_tick_cyc, 101);

    // Restart from RESULT, then reset while a spike is stalled.
    clear_image();
    image[10] = 8'd200;
    image[77] = 8'd30;
    mode = 3;
    start_run();
    check("rs_rdy", rdy, 0);
    check("rs_busy", busy, 1);
    check("rs_error", error, 0);
    n = 0;
    while (!spk_valid && n < 300) begin
      step();
      n++;
    end
    check("rs_first_valid", spk_valid, 1);
    check("rs_first_addr", spk_addr, 10);
    repeat (3) step();
    check("stall_valid", spk_valid, 1);
    check("stall_addr", spk_addr, 10);
    new_image = 1'b1;
    step();
    new_image = 1'b0;
    check("stall_ovr", overrun, 1);
    rst_n = 1'b0;
    #1;
    check("arst_spk_valid", spk_valid, 0);
    check("arst_spk_addr", spk_addr, 0);
    check("arst_tick", tick_valid, 0);
    check("arst_digit", digit, 0);
    check("arst_busy", busy, 0);
    check("arst_rdy", rdy, 0);
    check("arst_overrun", overrun, 0);
    check("arst_error", error, 0);
    step();
    rst_n = 1'b1;
    step();
    mode = 0;
    start_run();
    wait_ticks(20000);
    check("post_rst_first", (obs_q.size() > 0) ? obs_q[0] : -2, 10);
    check_stream("post_rst");
    finish_core(8'd3);
    result_ack = 1'b1;
    step();
    result_ack = 1'b0;
    check("final_rdy", rdy, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
